instr_mem_responder: RTL
========================

Name: instr_mem_responder

Overview:
- Memory-side responder for the instruction fetch interface: accepts word fetch requests, applies a configurable wait-state latency, and returns the instruction word with an error flag.
- Holds the instruction image in an internal word array; a program-load port writes the array.
- Sits between the fetch/decode stage (request initiator) and the testbench/program loader.

Parameters:
- BASE_ADDR, 32'h01000000, byte address of word 0 of the array.
- DEPTH_WORDS, 1024, number of 32-bit words in the array.
- WAIT_STATES, 1, extra cycles between request accept and response valid (0..15).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  fetch request present
- req_addr  input  32  byte address of the requested word
- req_ready  output  1  responder can accept a request this cycle
- rsp_valid  output  1  response word valid
- rsp_data  output  32  instruction word; 0 on error
- rsp_addr  output  32  address that produced this response
- rsp_err  output  1  misaligned or out-of-range request
- rsp_ready  input  1  initiator consumes the response
- load_en  input  1  write load_data to the array this cycle
- load_addr  input  32  byte address of the load write
- load_data  input  32  word to write

Behaviour:
- Reset (async, active-high): state IDLE; rsp_valid=0, rsp_data=0, rsp_addr=0, rsp_err=0, wait counter=0. Array contents are not cleared. An in-flight request is discarded; no response is produced for it after reset releases.
- FSM states: IDLE, WAIT, RESP.
- req_ready = !load_en && (state==IDLE || (state==RESP && rsp_ready)). This is combinational.
- Accept means req_valid && req_ready at a clock edge. On accept, req_addr is captured and the counter is loaded with WAIT_STATES.
  - WAIT_STATES==0: next state is RESP.
  - WAIT_STATES>0: next state is WAIT.
- WAIT: the counter decrements each cycle. When it reaches 1, the next state is RESP.
- Latency: rsp_valid rises exactly WAIT_STATES+1 clock edges after the accepting edge.
- Data is read from the array on the edge entering RESP and registered. rsp_data, rsp_addr and rsp_err are all registered.
- Address check, with a = captured address:
  - err when a[1:0]!=0, or a<BASE_ADDR, or a>=BASE_ADDR+4*DEPTH_WORDS.
  - On err: rsp_data=0 and rsp_err=1.
  - Otherwise: index=(a-BASE_ADDR)>>2 and rsp_err=0.
  - Subtraction is unsigned 32-bit. No wrap-around is allowed to alias into the array.
- RESP: rsp_valid, rsp_data, rsp_addr and rsp_err hold stable until rsp_valid && rsp_ready.
  - On handshake with no new accept: next state IDLE, rsp_valid=0.
  - On handshake with a simultaneous accept: the new request begins, and the next state follows the accept rule. With WAIT_STATES==0 this sustains one response per cycle.
- Load port:
  - Writes mem[index] on the edge where load_en=1.
  - Misaligned or out-of-range load addresses are silently ignored.
  - load_en blocks new accepts but does not stall an in-flight request.
- Read/write collision: if a load writes the same index on the edge entering RESP, rsp_data carries the new load_data (write-through bypass).
- req_valid with req_ready=0: no accept occurs, and the request has no side effects.

Optional Feature:
- Macro INSTR_MEM_STATS_EN.
- Defined: adds two 32-bit output ports.
  - stat_req_count: counts accepted requests.
  - stat_err_count: counts responses handshaken with rsp_err=1.
  - Both reset to 0 and saturate at 32'hFFFFFFFF.
- Undefined: the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Load 32'h00000537 at 32'h01000000; WAIT_STATES=1; request 32'h01000000 with rsp_ready=1 -> rsp_valid 2 edges after accept, rsp_data=32'h00000537, rsp_addr=32'h01000000, rsp_err=0.
- Request 32'h01000002, then 32'h00FFFFFC, then BASE_ADDR+4*DEPTH_WORDS -> each gives rsp_err=1, rsp_data=0. Request BASE_ADDR+4*DEPTH_WORDS-4 -> rsp_err=0 with the loaded word.
- Backpressure: hold rsp_ready=0 for 3 cycles during RESP with req_valid=1 -> rsp_valid/rsp_data/rsp_addr stable, req_ready=0, no second accept. Raising rsp_ready -> the next request is accepted on the same edge.
- WAIT_STATES=0: four back-to-back requests 32'h01000000..32'h0100000C with rsp_ready=1 -> four consecutive-cycle responses in order with matching data.
- Collision: load_en writes 32'hDEADBEEF to the requested word on the edge entering RESP -> rsp_data=32'hDEADBEEF. load_en held high in IDLE -> req_ready=0.
- Assert reset during WAIT -> rsp_valid=0 immediately (asynchronous). After release, req_ready=1 and no stale response appears. With INSTR_MEM_STATS_EN, both counters read 0.

Source files
------------

// File: rtl/instr_mem_responder.sv
// Instruction memory responder: word fetches with WAIT_STATES latency, error flagging and a program-load port.
// Define INSTR_MEM_STATS_EN to add saturating request/error counters (stat_req_count, stat_err_count).
module instr_mem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0100_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic [31:0] rsp_addr,
    output logic        rsp_err,
    input  logic        rsp_ready,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data
`ifdef INSTR_MEM_STATS_EN
    ,
    output logic [31:0] stat_req_count,
    output logic [31:0] stat_err_count
`endif
);

    localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CNT_W    = 4;
    localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        rd_addr;
    logic               accept;
    logic               enter_resp;
    logic               rd_bad;
    logic [IDX_W-1:0]   rd_idx;
    logic               ld_ok;
    logic [IDX_W-1:0]   ld_idx;
    logic [31:0]        rd_data;
    logic [31:0]        mem [DEPTH_WORDS];

    // 33-bit upper bound keeps the range check free of 32-bit wrap-around
    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a < BASE_ADDR) || ({1'b0, a} >= END_ADDR);
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return IDX_W'(off >> 2);
    endfunction

    // Next-state, handshake and read-address selection
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        rd_addr    = addr_q;
        enter_resp = 1'b0;
        req_ready  = !load_en && ((state_q == IDLE) || ((state_q == RESP) && rsp_ready));
        accept     = req_valid && req_ready;

        case (state_q)
            IDLE: ;
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            addr_d = req_addr;
            cnt_d  = CNT_W'(WAIT_STATES);
            if (WAIT_STATES == 0) begin
                state_d    = RESP;
                enter_resp = 1'b1;
                rd_addr    = req_addr;
            end else begin
                state_d = WAIT;
            end
        end
    end

    // Array read with write-through bypass for a same-edge load to the same word
    always_comb begin
        rd_bad  = addr_bad(rd_addr);
        rd_idx  = addr_idx(rd_addr);
        ld_ok   = load_en && !addr_bad(load_addr);
        ld_idx  = addr_idx(load_addr);
        rd_data = 32'd0;
        if (!rd_bad) begin
            rd_data = (ld_ok && (ld_idx == rd_idx)) ? load_data : mem[rd_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (ld_ok) mem[ld_idx] <= load_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_addr  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            rsp_valid <= (state_d == RESP);
            if (enter_resp) begin
                rsp_data <= rd_data;
                rsp_addr <= rd_addr;
                rsp_err  <= rd_bad;
            end
        end
    end

`ifdef INSTR_MEM_STATS_EN
    // Saturating activity counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_req_count <= '0;
            stat_err_count <= '0;
        end else begin
            if (accept && (stat_req_count != 32'hFFFF_FFFF))
                stat_req_count <= stat_req_count + 32'd1;
            if (rsp_valid && rsp_ready && rsp_err && (stat_err_count != 32'hFFFF_FFFF))
                stat_err_count <= stat_err_count + 32'd1;
        end
    end
`endif

endmodule
